// File: rtl/counter_cmd_arb.sv
// rtl/counter_cmd_arb.sv - two-requester round-robin command arbiter and sequencer for an 8-bit loadable counter
module counter_cmd_arb #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [1:0]         req_valid,
    input  logic [3:0]         req_op,
    input  logic [2*WIDTH-1:0] req_data,
    output logic [1:0]         req_ready,
    output logic               ld,
    output logic               inc,
    output logic [WIDTH-1:0]   data_in,
    input  logic [WIDTH-1:0]   q,
    output logic               done,
    output logic               done_id,
    output logic [WIDTH-1:0]   done_q,
    output logic               busy
);

    localparam logic [1:0] OP_LOAD = 2'b00;
    localparam logic [1:0] OP_INC  = 2'b01;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        EXEC   = 2'd1,
        SETTLE = 2'd2
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [1:0]         op_r;
    logic [WIDTH-1:0]   data_r;
    logic               id_r;
    logic               last_grant;
    logic [WIDTH-1:0]   cnt;

    logic               win_id;
    logic               accept;
    logic [1:0]         sel_op;
    logic [WIDTH-1:0]   sel_data;
    logic               sel_inc;
    logic               op_is_inc;
    logic               op_is_load;

    // On contention the requester that did not win last time gets the grant.
    assign win_id   = (&req_valid) ? ~last_grant : req_valid[1];
    assign accept   = (state == IDLE) && (|req_valid);
    assign sel_op   = win_id ? req_op[3:2] : req_op[1:0];
    assign sel_data = win_id ? req_data[2*WIDTH-1:WIDTH] : req_data[WIDTH-1:0];
    assign sel_inc  = (sel_op == OP_INC);

    assign op_is_inc  = (op_r == OP_INC);
    assign op_is_load = (op_r == OP_LOAD);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = (sel_inc && (sel_data == '0)) ? SETTLE : EXEC;
                end
            end
            EXEC: begin
                if (!op_is_inc || (cnt == WIDTH'(1))) begin
                    state_nxt = SETTLE;
                end
            end
            SETTLE:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        ld        = 1'b0;
        inc       = 1'b0;
        data_in   = '0;
        req_ready = 2'b00;
        busy      = (state != IDLE);
        case (state)
            IDLE: begin
                if (rst && (|req_valid)) begin
                    req_ready = win_id ? 2'b10 : 2'b01;
                end
            end
            EXEC: begin
                if (op_is_inc) begin
                    inc = 1'b1;
                end else begin
                    // CLEAR and the reserved opcode both load zero.
                    ld      = 1'b1;
                    data_in = op_is_load ? data_r : '0;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            op_r       <= 2'b00;
            data_r     <= '0;
            id_r       <= 1'b0;
            last_grant <= 1'b1;
            cnt        <= '0;
            done       <= 1'b0;
            done_id    <= 1'b0;
            done_q     <= '0;
        end else begin
            done <= (state == SETTLE);
            if (accept) begin
                op_r       <= sel_op;
                data_r     <= sel_data;
                id_r       <= win_id;
                last_grant <= win_id;
                cnt        <= sel_inc ? sel_data : '0;
            end else if ((state == EXEC) && op_is_inc) begin
                cnt <= cnt - WIDTH'(1);
            end
            if (state == SETTLE) begin
                done_q  <= q;
                done_id <= id_r;
            end
        end
    end

endmodule
